lisnoc_dma_transfer_table: RTL

//  Next-generation DMA request/status table between the bus interface and the DMA control

---
 rtl/lisnoc_dma_transfer_table.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/lisnoc_dma_transfer_table.sv
// lisnoc_dma_transfer_table: DMA request/status table with round-robin dispatch and latched irq; LISNOC_DMA_TABLE_ERROR_EN adds an ERROR state
`ifndef DMA_REQUEST_WIDTH
`define DMA_REQUEST_WIDTH 32
`endif
module lisnoc_dma_transfer_table #(
  parameter int table_entries = 8,
  parameter int req_width = `DMA_REQUEST_WIDTH,
  localparam int ptr_width = $clog2(table_entries)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [req_width-1:0]     if_write_req,
  input  logic [req_width-1:0]     if_write_mask,
  input  logic [ptr_width-1:0]     if_write_pos,
  input  logic                     if_write_en,
  output logic                     if_write_err,
  input  logic [ptr_width-1:0]     if_valid_pos,
  input  logic                     if_valid_en,
  input  logic                     if_valid_set,
  input  logic                     if_validrd_en,
  input  logic [table_entries-1:0] if_irq_mask,
  input  logic [ptr_width-1:0]     ctrl_read_pos,
  input  logic                     ctrl_read_en,
  output logic [req_width-1:0]     ctrl_read_req,
  output logic [ptr_width-1:0]     ctrl_next_pos,
  output logic                     ctrl_next_valid,
  input  logic [ptr_width-1:0]     ctrl_start_pos,
  input  logic                     ctrl_start_en,
  input  logic [ptr_width-1:0]     ctrl_done_pos,
  input  logic                     ctrl_done_en,
`ifdef LISNOC_DMA_TABLE_ERROR_EN
  input  logic [ptr_width-1:0]     ctrl_error_pos,
  input  logic                     ctrl_error_en,
  output logic [table_entries-1:0] error,
`endif
  output logic [table_entries-1:0] valid,
  output logic [table_entries-1:0] done,
  output logic                     irq
);
`ifdef LISNOC_DMA_TABLE_ERROR_EN
  localparam int sw = 3;
  localparam logic [sw-1:0] S_ERROR = sw'(4);
`else
  localparam int sw = 2;
`endif
  localparam logic [sw-1:0] S_IDLE = sw'(0);
  localparam logic [sw-1:0] S_VALID = sw'(1);
  localparam logic [sw-1:0] S_ACTIVE = sw'(2);
  localparam logic [sw-1:0] S_DONE = sw'(3);

  logic [sw-1:0] r_state [table_entries];
  logic [req_width-1:0] r_req [table_entries];
  logic [table_entries-1:0] r_pending;
  logic [ptr_width-1:0] r_rr_ptr;
  logic [ptr_width-1:0] w_idx;
  logic [table_entries-1:0] w_set_hit, w_rd_hit, w_err_hit, w_done_hit, w_start_hit;

  // per-entry strobe decode; a start only counts if no set/clear overrides it
  always_comb begin
    w_set_hit = '0;
    w_rd_hit = '0;
    w_err_hit = '0;
    w_done_hit = '0;
    w_start_hit = '0;
    for (int i = 0; i < table_entries; i++) begin
      w_set_hit[i] = if_valid_en && if_valid_pos == ptr_width'(i);
`ifdef LISNOC_DMA_TABLE_ERROR_EN
      w_rd_hit[i] = if_validrd_en && if_valid_pos == ptr_width'(i) && (r_state[i] == S_DONE || r_state[i] == S_ERROR);
      w_err_hit[i] = ctrl_error_en && ctrl_error_pos == ptr_width'(i) && r_state[i] == S_ACTIVE;
`else
      w_rd_hit[i] = if_validrd_en && if_valid_pos == ptr_width'(i) && r_state[i] == S_DONE;
`endif
      w_done_hit[i] = ctrl_done_en && ctrl_done_pos == ptr_width'(i) && r_state[i] == S_ACTIVE;
      w_start_hit[i] = ctrl_start_en && ctrl_start_pos == ptr_width'(i) && r_state[i] == S_VALID && !w_set_hit[i];
    end
  end

  // status vectors straight from the entry states
  always_comb begin
    valid = '0;
    done = '0;
`ifdef LISNOC_DMA_TABLE_ERROR_EN
    error = '0;
`endif
    for (int i = 0; i < table_entries; i++) begin
      valid[i] = r_state[i] == S_VALID;
      done[i] = r_state[i] == S_DONE;
`ifdef LISNOC_DMA_TABLE_ERROR_EN
      error[i] = r_state[i] == S_ERROR;
`endif
    end
  end

  // round-robin: lowest offset from rr_ptr wins, so scan offsets downwards
  always_comb begin
    ctrl_next_pos = '0;
    ctrl_next_valid = 1'b0;
    w_idx = '0;
    for (int k = table_entries - 1; k >= 0; k--) begin
      w_idx = r_rr_ptr + ptr_width'(k);
      if (valid[w_idx]) begin
        ctrl_next_pos = w_idx;
        ctrl_next_valid = 1'b1;
      end
    end
  end

  // entry life-cycle, pending interrupts, rr pointer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < table_entries; i++) r_state[i] <= S_IDLE;
      r_pending <= '0;
      r_rr_ptr <= '0;
      irq <= 1'b0;
      if_write_err <= 1'b0;
      ctrl_read_req <= '0;
    end else begin
      for (int i = 0; i < table_entries; i++) begin
        if (w_set_hit[i]) begin
          r_state[i] <= if_valid_set ? S_VALID : S_IDLE;
          r_pending[i] <= 1'b0;
        end else if (w_rd_hit[i]) begin
          r_state[i] <= S_IDLE;
          r_pending[i] <= 1'b0;
`ifdef LISNOC_DMA_TABLE_ERROR_EN
        end else if (w_err_hit[i]) begin
          r_state[i] <= S_ERROR;
          r_pending[i] <= 1'b1;
`endif
        end else if (w_done_hit[i]) begin
          r_state[i] <= S_DONE;
          r_pending[i] <= 1'b1;
        end else if (w_start_hit[i]) begin
          r_state[i] <= S_ACTIVE;
        end
      end
      if (|w_start_hit) r_rr_ptr <= ctrl_start_pos + 1'b1;
      irq <= |(r_pending & if_irq_mask);
      if_write_err <= if_write_en && r_state[if_write_pos] == S_ACTIVE;
      if (ctrl_read_en) ctrl_read_req <= r_req[ctrl_read_pos];
    end
  end

  // masked request write, dropped while the entry is being processed
  always_ff @(posedge clk) begin
    if (if_write_en && r_state[if_write_pos] != S_ACTIVE)
      r_req[if_write_pos] <= (~if_write_mask & r_req[if_write_pos]) | (if_write_mask & if_write_req);
  end
endmodule
